// File: rtl/dump_pkg.sv
// Shared definitions for the end-of-run state dump transmitter: FSM state
// encoding, stream header magic, section sizes and the total word count.
// The memory section is present only when DUMP_DMEM_EN is defined.
package dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PC,
    S_RADDR,
    S_RSEND,
    S_MADDR,
    S_MSEND,
    S_DONE
  } state_t;

  localparam logic [15:0] HDR_MAGIC = 16'h5D0C;
  localparam int          REG_WORDS = 32;
  localparam int          DM_WORDS  = 128;

  // Words in one dump: header + captured PC + registers (+ data memory).
  function automatic logic [15:0] dump_word_count();
`ifdef DUMP_DMEM_EN
    return 16'(2 + REG_WORDS + DM_WORDS);
`else
    return 16'(2 + REG_WORDS);
`endif
  endfunction

endpackage

// File: rtl/tx_word_hold.sv
// One-entry output register for the dump word stream. A load places a new
// word on the stream; the word is held stable until the sink accepts it.
module tx_word_hold (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic        i_last,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic        o_last,
  output logic        o_free
);

  logic        r_valid;
  logic [31:0] r_data;
  logic        r_last;

  // Capture a word on load, drop valid/last once the sink takes it.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // pre-edge values regardless of statement order.
    if (!rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_free  = !r_valid;

endmodule

// File: rtl/state_dump_tx.sv
// End-of-run state dump transmitter. On a start pulse or when the fetch PC
// reaches the stop point it halts the core and streams header, captured PC,
// r0..r31 and (with DUMP_DMEM_EN defined) the data memory, one word per
// valid/ready handshake. Without DUMP_DMEM_EN the dump ends at r31.
module state_dump_tx
  import dump_pkg::*;
#(
  parameter int STOP_INSTR = 200
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc,
  input  logic        start,
  output logic        cpu_halt,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic [6:0]  dm_addr,
  input  logic [31:0] dm_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] tx_data,
  output logic        tx_last,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] STOP_PC  = 32'(4 * STOP_INSTR);
  localparam logic [4:0]  REG_LAST = 5'(REG_WORDS - 1);
`ifdef DUMP_DMEM_EN
  localparam logic [6:0]  MEM_LAST = 7'(DM_WORDS - 1);
  localparam logic        REGS_END_DUMP = 1'b0;
`else
  localparam logic        REGS_END_DUMP = 1'b1;
`endif

  state_t      r_state;
  logic [31:0] r_pc;
  logic [4:0]  r_ridx;
`ifdef DUMP_DMEM_EN
  logic [6:0]  r_midx;
`endif

  logic        w_trigger;
  logic        w_hs;
  logic        w_free;
  logic        w_load;
  logic [31:0] w_ld_data;
  logic        w_ld_last;

  assign w_trigger = start || (pc == STOP_PC);
  assign w_hs      = tx_valid && tx_ready;

  // Choose which word, if any, enters the output register this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and infers a latch.
    w_load    = 1'b0;
    w_ld_data = '0;
    w_ld_last = 1'b0;
    case (r_state)
      S_IDLE: if (w_trigger) begin
        w_load    = 1'b1;
        w_ld_data = {HDR_MAGIC, dump_word_count()};
      end
      S_HDR: if (w_hs) begin
        w_load    = 1'b1;
        w_ld_data = r_pc;
      end
      S_RADDR: if (w_free) begin
        w_load    = 1'b1;
        w_ld_data = (r_ridx == '0) ? '0 : reg_data;
        w_ld_last = REGS_END_DUMP && (r_ridx == REG_LAST);
      end
`ifdef DUMP_DMEM_EN
      S_MADDR: if (w_free) begin
        w_load    = 1'b1;
        w_ld_data = dm_data;
        w_ld_last = (r_midx == MEM_LAST);
      end
`endif
      default: ;
    endcase
  end

  // Dump sequencer: walks header, PC, registers and memory, then parks in DONE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ridx  <= '0;
`ifdef DUMP_DMEM_EN
      r_midx  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (w_trigger) begin
          r_pc    <= pc;
          r_state <= S_HDR;
        end
        S_HDR: if (w_hs) r_state <= S_PC;
        S_PC: if (w_hs) begin
          r_ridx  <= '0;
          r_state <= S_RADDR;
        end
        S_RADDR: if (w_free) r_state <= S_RSEND;
        S_RSEND: if (w_hs) begin
          if (r_ridx != REG_LAST) begin
            r_ridx  <= r_ridx + 5'd1;
            r_state <= S_RADDR;
          end else begin
`ifdef DUMP_DMEM_EN
            r_midx  <= '0;
            r_state <= S_MADDR;
`else
            r_state <= S_DONE;
`endif
          end
        end
`ifdef DUMP_DMEM_EN
        S_MADDR: if (w_free) r_state <= S_MSEND;
        S_MSEND: if (w_hs) begin
          if (r_midx != MEM_LAST) begin
            r_midx  <= r_midx + 7'd1;
            r_state <= S_MADDR;
          end else begin
            r_state <= S_DONE;
          end
        end
`endif
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  tx_word_hold u_hold (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_load),
    .i_data  (w_ld_data),
    .i_last  (w_ld_last),
    .i_ready (tx_ready),
    .o_valid (tx_valid),
    .o_data  (tx_data),
    .o_last  (tx_last),
    .o_free  (w_free)
  );

  assign reg_sel  = r_ridx;
`ifdef DUMP_DMEM_EN
  assign dm_addr  = r_midx;
`else
  assign dm_addr  = '0;
  wire   w_unused_dm = ^dm_data;
`endif
  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign cpu_halt = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);

endmodule

// File: doc/state_dump_tx.md
# state_dump_tx

End-of-run state dump transmitter for the pipeline CPU. When the program reaches its stop point, or on an explicit start pulse, it freezes the core. It then reads out the captured PC, all 32 architectural registers and the data memory, one word at a time. Each word goes out over a valid/ready word stream to a host-side sink such as a UART bridge or a capture FIFO. It sits beside the CPU core in the top-level computer, on the register-file debug read port and a data-memory read port.

## Interface
- STOP_INSTR, 200, instruction index at which the dump triggers automatically
- STOP_PC, 4*STOP_INSTR, byte PC compared against `pc`
- DM_WORDS, 128, number of data-memory words dumped
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- pc  in  32  current fetch PC of the core
- start  in  1  one-cycle manual dump request
- cpu_halt  out  1  freezes the core while dumping and after
- reg_sel  out  5  register-file debug read select
- reg_data  in  32  register-file debug read data, combinational from reg_sel
- dm_addr  out  7  data-memory word index
- dm_data  in  32  data-memory read data, combinational from dm_addr
- tx_valid  out  1  stream word valid
- tx_ready  in  1  sink accepts the word
- tx_data  out  32  stream word
- tx_last  out  1  final word of the dump
- busy  out  1  dump in progress
- done  out  1  dump complete (sticky)

## Operation
- Trigger condition: state IDLE and (`start` or `pc == STOP_PC`). Two triggers in the same cycle start a single dump. `pc` is captured into a register at the trigger edge.
- Dump order:
  - Header = {16'h5D0C, 16-bit total word count}.
  - Captured PC.
  - r0..r31. The r0 word is forced to 0 regardless of `reg_data`.
  - dmem[0..DM_WORDS-1].
- Total word count is 2+32+DM_WORDS, which is 162 by default.
- FSM states: IDLE, HDR, PC, RADDR, RSEND, MADDR, MSEND, DONE.
  - IDLE→HDR on trigger.
  - HDR→PC on handshake.
  - PC→RADDR on handshake.
  - RADDR→RSEND after 1 cycle.
  - RSEND→RADDR on handshake while index < 31.
  - RSEND→MADDR on handshake at index 31.
  - MADDR/MSEND behave the same way with index up to DM_WORDS-1.
  - Final handshake→DONE.
- In xADDR states, the address (`reg_sel` or `dm_addr`) = index. Data is sampled into the tx_data register at the end of that cycle.
- Index counters are 5-bit for registers and 7-bit for memory. They reset to 0 on entry to each section and increment on handshake. No wrap occurs; the terminal index exits the section.
- DONE is terminal until reset. `start` and `pc` matches are ignored in DONE and while busy.
- busy = state not in {IDLE, DONE}.
- cpu_halt = state != IDLE.

## Timing
- Reset values: all outputs 0; state IDLE; indices 0.
- Trigger sampled at edge N. At N+1: busy=1, cpu_halt=1, tx_valid=1 with the header.
- Handshake = tx_valid && tx_ready at a rising edge.
- Once tx_valid is asserted, tx_data and tx_last hold stable until the handshake.
- tx_valid is low in xADDR cycles. Minimum cost is 2 cycles per register or memory word and 1 cycle each for header and PC.
- With tx_ready held at 1, the default dump is 2+2*(32+DM_WORDS)=322 cycles from the first valid word to the last handshake.
- tx_last is high only alongside the final word's tx_valid.
- done rises the cycle after the final handshake; busy falls at the same time.
- rstn low at any point, including mid-dump: at the next edge, all outputs go to reset values and the partial dump is abandoned. After reset, a new trigger restarts from the header.

## Configuration
- DUMP_DMEM_EN:
  - Defined: the memory section is included and the header count is 162.
  - Undefined: the MADDR/MSEND states and memory index are compiled out, and dm_addr is tied to 0. The dump ends at r31 with tx_last there, and the header count is 34 (0x0022).

## Structure
- Package dump_pkg: state enum, HDR_MAGIC (16'h5D0C), REG_WORDS (32), and a word-count function of DM_WORDS and the macro.
- Sub-module tx_word_hold: a one-entry output register that owns tx_valid, tx_data and tx_last.
  - Load strobe from the FSM.
  - Clears valid on handshake.
  - Asserts `free` to the FSM.

## Test plan
- Auto-trigger test (macro defined, tx_ready=1):
  - Stimulus: drive pc=0x320.
  - Required: 162 words. Word0=0x5D0C00A2, word1=0x00000320, word2=0 even with reg_data=0xFFFFFFFF. tx_last only on word 162. done=1 one cycle after.
- Backpressure test:
  - Stimulus: tx_ready low for 5 cycles after the header, then toggling every cycle.
  - Required: tx_data stable while not accepted; no lost or duplicated words; same 162-word sequence.
- Trigger rejection test:
  - Stimulus: start pulses while busy, and again after done.
  - Required: ignored; exactly one header observed.
- Mid-dump reset test:
  - Stimulus: rstn low for 1 cycle during the register section.
  - Required: next cycle tx_valid=0, busy=0, cpu_halt=0. A new start yields a complete dump beginning 0x5D0C00A2.
- Macro-off test:
  - Stimulus: build without DUMP_DMEM_EN.
  - Required: 34 words, header 0x5D0C0022, tx_last on the r31 word.
- Simultaneous trigger test:
  - Stimulus: start and pc==STOP_PC in the same cycle.
  - Required: single dump; word1=0x00000320.
